dsp_div_signed_iterative: RTL and testbench
===========================================

// Module: dsp_div_signed_iterative
// PURPOSE
//  Signed iterative divider that undoes a signed MAC product: given P (dividend) and A
//  (divisor), it recovers B (quotient) and R (remainder) with P = A*B + R.
//  Sits downstream of dsp_mul_signed_reg_* blocks for result normalisation and
//  self-check. One quotient bit per clock; start/busy/done handshake.
// PARAMETERS
//  A_W   20          divisor width (signed), matches MAC A operand
//  B_W   18          quotient width (signed), matches MAC B operand
//  P_W   A_W+B_W     dividend width (signed), matches MAC P output; do not override
// PORTS
//  clk         in   1    rising-edge clock
//  reset       in   1    asynchronous, active-low reset
//  start_i     in   1    request; sampled only in IDLE
//  P_i         in   P_W  signed dividend; sampled with start_i
//  A_i         in   A_W  signed divisor; sampled with start_i
//  busy_o      out  1    high from the edge accepting start_i until done_o
//  done_o      out  1    one-cycle pulse; B_o/R_o/flags valid from this cycle
//  B_o         out  B_W  signed quotient
//  R_o         out  A_W  signed remainder
//  div_zero_o  out  1    A_i was 0 for this operation
//  overflow_o  out  1    true quotient does not fit in B_W signed bits
// BEHAVIOUR
//  - Reset (reset=0, any time incl. mid-operation): state=IDLE; busy_o, done_o, B_o,
//    R_o, div_zero_o, overflow_o all 0; partial work discarded. No output on release.
//  - FSM: IDLE -> CALC -> FIX -> IDLE.
//    IDLE: on edge with start_i=1: latch |P_i|, |A_i|, sign(P_i), sign(A_i); busy_o=1.
//      If A_i==0 go to FIX directly (counter skipped), else CALC with counter=P_W-1.
//    CALC: one restoring step per edge on magnitudes (P_W-bit quotient, A_W-bit
//      remainder; shift/subtract kept 1 bit wider than A_W to avoid wrap).
//      After step with counter==0 -> FIX.
//    FIX: sign-correct, saturate, register outputs; done_o=1 for this cycle, busy_o=0,
//      state=IDLE.
//  - Latency: edge 0 accepts start_i; done_o is high after edge P_W+1 (edge 39 by
//    default). Divide-by-zero: done_o high after edge 1.
//  - Rounding: truncation toward zero. R_o takes sign of P_i, |R_o| < |A_i|.
//    B_o negative iff sign(P_i) xor sign(A_i) and magnitude nonzero.
//  - |P_i| of -2^(P_W-1) and |A_i| of -2^(A_W-1) handled as unsigned magnitudes
//    (no overflow in abs).
//  - overflow_o=1 when the signed quotient is outside [-2^(B_W-1), 2^(B_W-1)-1];
//    B_o saturates to the bound of the quotient sign; R_o = P - A*B_o truncated
//    to A_W bits (informative only).
//  - div_zero_o=1: B_o=0, R_o=0, overflow_o=0.
//  - start_i while busy_o=1 (incl. FIX cycle) is ignored, not queued.
//  - start_i on the cycle after done_o is accepted; back-to-back ops allowed.
//  - B_o, R_o, flags hold their value until the next FIX or reset; flags are
//    cleared when a new start_i is accepted.
// TESTING
//  1. Reset low at cycle 10 of an op -> busy_o=0, done_o=0, all outputs 0;
//     no done_o after release.
//  2. P=10, A=5 -> done_o after edge 39, B_o=2, R_o=0, flags 0.
//  3. P=-11, A=5 -> B_o=-2, R_o=-1.
//     P=11, A=-5 -> B_o=-2, R_o=1.
//     P=-11, A=-5 -> B_o=2, R_o=-1.
//  4. P=1234, A=0 -> done_o after edge 1, div_zero_o=1, B_o=0, R_o=0.
//     P=-2^37, A=-1 -> overflow_o=1, B_o=131071.
//     P=2^36, A=1 -> overflow_o=1, B_o=131071.
//  5. 32 random signed A!=0, B; R random with |R|<|A| and sign(R)=sign(A*B+R);
//     feed P=A*B+R -> B_o==B and R_o==R each op.
//  6. start_i pulsed at edges 5 and 38 of an op -> ignored, exactly one done_o;
//     start_i on the cycle after done_o -> accepted immediately.

Source files
------------

// File: rtl/dsp_div_signed_iterative.sv
// Signed iterative divider: recovers quotient B and remainder R from P = A*B + R.
// Restoring division on magnitudes, one quotient bit per clock, followed by a
// single sign-fix/saturate cycle. Truncates toward zero; R takes the sign of P.
//
// Handshake: start_i is sampled only while the FSM is IDLE; the accepting edge
// latches P_i/A_i and raises busy_o. busy_o stays high until the edge that raises
// done_o, which is a one-cycle pulse. B_o/R_o/flags are valid from the done_o cycle
// and hold until the next result or reset. A start_i seen while busy (including the
// FIX cycle) is dropped, never queued; the cycle right after done_o is IDLE again.
module dsp_div_signed_iterative #(
   parameter int A_W = 20,
   parameter int B_W = 18,
   parameter int P_W = A_W + B_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic signed [P_W-1:0] P_i,
   input  logic signed [A_W-1:0] A_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic signed [B_W-1:0] B_o,
   output logic signed [A_W-1:0] R_o,
   output logic                  div_zero_o,
   output logic                  overflow_o,
   output logic [1:0]            dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   localparam int               CNT_W     = $clog2(P_W);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(P_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [P_W-1:0]   P_ONE     = P_W'(1);
   localparam logic [A_W-1:0]   A_ONE     = A_W'(1);
   localparam logic [B_W-1:0]   B_ONE     = B_W'(1);
   // Largest quotient magnitudes that still fit in B_W signed bits.
   localparam logic [P_W-1:0]   Q_POS_MAX = P_W'((64'd1 << (B_W - 1)) - 64'd1);
   localparam logic [P_W-1:0]   Q_NEG_MAX = P_W'(64'd1 << (B_W - 1));
   localparam logic [B_W-1:0]   B_MAX     = {1'b0, {(B_W-1){1'b1}}};
   localparam logic [B_W-1:0]   B_MIN     = {1'b1, {(B_W-1){1'b0}}};

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_step;
   logic             w_fix;

   logic [P_W-1:0]   r_q;        // dividend magnitude shifting out, quotient shifting in
   logic [A_W-1:0]   r_rem;      // partial remainder magnitude
   logic [A_W-1:0]   r_dm;       // divisor magnitude
   logic             r_sp;       // sign of P
   logic             r_sa;       // sign of A
   logic             r_dz;       // this operation divides by zero
   logic [CNT_W-1:0] r_cnt;

   logic             r_busy;
   logic             r_done;
   logic [B_W-1:0]   r_b;
   logic [A_W-1:0]   r_r;
   logic             r_dz_flag;
   logic             r_ovf;

   logic [P_W-1:0]   w_p_mag;
   logic [A_W-1:0]   w_a_mag;
   logic             w_a_zero;
   logic [A_W:0]     w_trial;
   logic             w_ge;
   logic [A_W-1:0]   w_diff;
   logic [A_W-1:0]   w_rem_nxt;
   logic             w_neg;
   logic             w_ovf;
   logic [B_W-1:0]   w_b_fit;
   logic [B_W-1:0]   w_sat;
   logic [A_W-1:0]   w_r_fit;
   logic [A_W-1:0]   w_a_s;
   logic [A_W-1:0]   w_bt_lo;
   logic [A_W-1:0]   w_sat_ext;
   logic [A_W-1:0]   w_r_ovf;

   // Operand magnitudes; the most negative values map to their unsigned magnitude.
   assign w_p_mag  = P_i[P_W-1] ? (~P_i + P_ONE) : P_i;
   assign w_a_mag  = A_i[A_W-1] ? (~A_i + A_ONE) : A_i;
   assign w_a_zero = (A_i == '0);

   // Restoring step: the trial is one bit wider than the divisor so it never wraps.
   // The difference only matters when trial >= divisor, where it fits in A_W bits.
   assign w_trial   = {r_rem, r_q[P_W-1]};
   assign w_ge      = (w_trial >= {1'b0, r_dm});
   assign w_diff    = w_trial[A_W-1:0] - r_dm;
   assign w_rem_nxt = w_ge ? w_diff : w_trial[A_W-1:0];

   // Sign correction and saturation of the finished magnitudes.
   assign w_neg   = (r_sp ^ r_sa) & (r_q != '0);
   assign w_ovf   = w_neg ? (r_q > Q_NEG_MAX) : (r_q > Q_POS_MAX);
   assign w_b_fit = w_neg ? (~r_q[B_W-1:0] + B_ONE) : r_q[B_W-1:0];
   assign w_sat   = w_neg ? B_MIN : B_MAX;
   assign w_r_fit = r_sp ? (~r_rem + A_ONE) : r_rem;

   // Saturated remainder P - A*B_sat, rebuilt modulo 2^A_W as A*(B_true - B_sat) + R
   // so the original dividend does not have to be kept. Assumes A_W > B_W.
   assign w_a_s     = r_sa ? (~r_dm + A_ONE) : r_dm;
   assign w_bt_lo   = w_neg ? (~r_q[A_W-1:0] + A_ONE) : r_q[A_W-1:0];
   assign w_sat_ext = {{(A_W-B_W){w_sat[B_W-1]}}, w_sat};
   assign w_r_ovf   = w_a_s * (w_bt_lo - w_sat_ext) + w_r_fit;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state decode and per-state datapath strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_fix       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_accept    = 1'b1;
               w_state_nxt = w_a_zero ? S_FIX : S_CALC;
            end
         end
         S_CALC: begin
            w_step = 1'b1;
            if (r_cnt == '0) w_state_nxt = S_FIX;
         end
         S_FIX: begin
            w_fix       = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: latch operands, iterate, then register the corrected result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q       <= '0;
         r_rem     <= '0;
         r_dm      <= '0;
         r_sp      <= 1'b0;
         r_sa      <= 1'b0;
         r_dz      <= 1'b0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_b       <= '0;
         r_r       <= '0;
         r_dz_flag <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_q       <= w_p_mag;
            r_rem     <= '0;
            r_dm      <= w_a_mag;
            r_sp      <= P_i[P_W-1];
            r_sa      <= A_i[A_W-1];
            r_dz      <= w_a_zero;
            r_cnt     <= CNT_LAST;
            r_busy    <= 1'b1;
            r_dz_flag <= 1'b0;
            r_ovf     <= 1'b0;
         end
         if (w_step) begin
            r_q   <= {r_q[P_W-2:0], w_ge};
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt - CNT_ONE;
         end
         if (w_fix) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            if (r_dz) begin
               r_b       <= '0;
               r_r       <= '0;
               r_dz_flag <= 1'b1;
               r_ovf     <= 1'b0;
            end else begin
               r_b       <= w_ovf ? w_sat : w_b_fit;
               r_r       <= w_ovf ? w_r_ovf : w_r_fit;
               r_dz_flag <= 1'b0;
               r_ovf     <= w_ovf;
            end
         end
      end
   end

   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign B_o         = r_b;
   assign R_o         = r_r;
   assign div_zero_o  = r_dz_flag;
   assign overflow_o  = r_ovf;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_dsp_div_signed_iterative.sv
// Directed bench for dsp_div_signed_iterative: reset, signs, boundaries,
// divide-by-zero, saturation, constructed random quotients and start handling.
module tb_dsp_div_signed_iterative;

   localparam int A_W = 20;
   localparam int B_W = 18;
   localparam int P_W = A_W + B_W;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  start_i = 1'b0;
   logic signed [P_W-1:0] P_i = '0;
   logic signed [A_W-1:0] A_i = '0;
   logic                  busy_o;
   logic                  done_o;
   logic signed [B_W-1:0] B_o;
   logic signed [A_W-1:0] R_o;
   logic                  div_zero_o;
   logic                  overflow_o;
   logic [1:0]            dbg_state_o;

   int n_checks = 0;
   int n_fail   = 0;
   int lat;
   int n_done;
   int done_edge;

   // Clock and reset.
   always #5 clk = ~clk;

   dsp_div_signed_iterative #(.A_W(A_W), .B_W(B_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_i     (start_i),
      .P_i         (P_i),
      .A_i         (A_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .B_o         (B_o),
      .R_o         (R_o),
      .div_zero_o  (div_zero_o),
      .overflow_o  (overflow_o),
      .dbg_state_o (dbg_state_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // Issue one operation and return the number of edges after the accepting edge
   // until done_o is seen (-1 if it never arrives).
   task automatic run_op(input logic signed [P_W-1:0] p, input logic signed [A_W-1:0] a,
                         output int l);
      @(negedge clk);
      P_i     = p;
      A_i     = a;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      chk("accept_busy", busy_o, 1);
      chk("accept_flags", {div_zero_o, overflow_o}, 0);
      l = -1;
      for (int e = 1; e <= 100; e++) begin
         @(posedge clk);
         #1;
         if (done_o) begin
            l = e;
            break;
         end
      end
      if (l > 0) chk("done_busy_low", busy_o, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      // Power-on reset.
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_B", B_o, 0);
      chk("rst_R", R_o, 0);
      chk("rst_flags", {div_zero_o, overflow_o}, 0);
      chk("rst_state", dbg_state_o, 0);
      @(negedge clk);
      reset = 1'b1;

      // Basic quotient and latency.
      run_op(38'sd10, 20'sd5, lat);
      chk("t2_lat", lat, 39);
      chk("t2_B", B_o, 2);
      chk("t2_R", R_o, 0);
      chk("t2_flags", {div_zero_o, overflow_o}, 0);
      @(posedge clk);
      #1;
      chk("t2_done_pulse", done_o, 0);
      chk("t2_B_hold", B_o, 2);

      // Sign combinations.
      run_op(-38'sd11, 20'sd5, lat);
      chk("t3a_B", B_o, -2);
      chk("t3a_R", R_o, -1);
      run_op(38'sd11, -20'sd5, lat);
      chk("t3b_B", B_o, -2);
      chk("t3b_R", R_o, 1);
      run_op(-38'sd11, -20'sd5, lat);
      chk("t3c_B", B_o, 2);
      chk("t3c_R", R_o, -1);

      // Divide by zero, then a normal op clears the flag on accept.
      run_op(38'sd1234, 20'sd0, lat);
      chk("t4z_lat", lat, 1);
      chk("t4z_dz", div_zero_o, 1);
      chk("t4z_ovf", overflow_o, 0);
      chk("t4z_B", B_o, 0);
      chk("t4z_R", R_o, 0);

      // Quotient exactly at the negative bound fits.
      run_op(-38'sd131072, 20'sd1, lat);
      chk("t4n_ovf", overflow_o, 0);
      chk("t4n_B", B_o, -131072);
      chk("t4n_R", R_o, 0);

      // One past the positive bound saturates; R = P - A*B_o.
      run_op(38'sd131072, 20'sd1, lat);
      chk("t4p_ovf", overflow_o, 1);
      chk("t4p_B", B_o, 131071);
      chk("t4p_R", R_o, 1);

      // Negative saturation: -2^36 / 1.
      run_op(38'h30_0000_0000, 20'sd1, lat);
      chk("t4m_ovf", overflow_o, 1);
      chk("t4m_B", B_o, -131072);
      chk("t4m_R", R_o, 131072);

      // Most negative dividend over -1, then 2^36 / 1.
      run_op(38'h20_0000_0000, -20'sd1, lat);
      chk("t4e_lat", lat, 39);
      chk("t4e_ovf", overflow_o, 1);
      chk("t4e_B", B_o, 131071);
      chk("t4e_R", R_o, 131071);
      run_op(38'h10_0000_0000, 20'sd1, lat);
      chk("t4f_ovf", overflow_o, 1);
      chk("t4f_B", B_o, 131071);
      chk("t4f_R", R_o, -131071);

      // Reset in the middle of an operation.
      @(negedge clk);
      P_i = 38'sd77;
      A_i = 20'sd3;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t1_busy", busy_o, 0);
      chk("t1_done", done_o, 0);
      chk("t1_B", B_o, 0);
      chk("t1_R", R_o, 0);
      chk("t1_flags", {div_zero_o, overflow_o}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      n_done = 0;
      for (int e = 0; e < 60; e++) begin
         @(posedge clk);
         #1;
         if (done_o) n_done++;
      end
      chk("t1_no_done", n_done, 0);
      chk("t1_idle_busy", busy_o, 0);

      // Constructed operands: P = A*B + R with |R| < |A| and sign(R) = sign(P).
      for (int k = 0; k < 32; k++) begin
         longint a, b, r, ab, am, p;
         a = longint'($urandom_range(0, 1048575)) - 524288;
         if (a == 0) a = 1;
         b = longint'($urandom_range(0, 262142)) - 131071;
         am = (a < 0) ? -a : a;
         r = longint'($urandom_range(0, 32'(am - 1)));
         ab = a * b;
         if (ab < 0 || (ab == 0 && $urandom_range(0, 1) == 1)) r = -r;
         p = ab + r;
         run_op(p[P_W-1:0], a[A_W-1:0], lat);
         chk("rnd_lat", lat, 39);
         chk("rnd_B", B_o, b);
         chk("rnd_R", R_o, r);
      end

      // start_i while busy (mid-CALC, last CALC edge, FIX edge) is dropped.
      @(negedge clk);
      P_i = 38'sd100;
      A_i = 20'sd7;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      n_done = 0;
      done_edge = -1;
      for (int e = 1; e <= 39; e++) begin
         @(negedge clk);
         P_i = 38'sd999;
         A_i = 20'sd3;
         start_i = (e == 5 || e == 38 || e == 39);
         @(posedge clk);
         #1;
         start_i = 1'b0;
         if (done_o) begin
            n_done++;
            done_edge = e;
         end
      end
      chk("t6_n_done", n_done, 1);
      chk("t6_done_edge", done_edge, 39);
      chk("t6_B", B_o, 14);
      chk("t6_R", R_o, 2);

      // Back-to-back: start on the cycle right after done_o.
      run_op(-38'sd999, 20'sd3, lat);
      chk("t6b_lat", lat, 39);
      chk("t6b_B", B_o, -333);
      chk("t6b_R", R_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
